// File: rtl/mp_pkg.sv
// Definitions shared by the bytecode loader, the microprocessor and the ALU.
package mp_pkg;
  localparam int         DEPTH   = 256;
  localparam logic [7:0] HALT_OP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } ld_state_t;
endpackage

// File: rtl/prog_ram.sv
// Program storage: one write port and one registered read port, write-first on an address match.
module prog_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [DEPTH];

  // Read data only advances on a read so the last fetched byte stays on the output.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_data <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/bytecode_loader.sv
// Streams a bytecode program into program RAM and serves processor fetches with one-cycle latency.
module bytecode_loader #(
  parameter int         DEPTH   = mp_pkg::DEPTH,
  parameter logic [7:0] HALT_OP = mp_pkg::HALT_OP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       clear,
  input  logic       fetch_req,
  input  logic [7:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       fetch_valid,
  output logic [8:0] prog_len,
  output logic       loaded,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);

  mp_pkg::ld_state_t state;
  logic [AW-1:0]     wr_ptr;
  logic              xfer;
  logic [8:0]        len_eff;
  logic              in_range_q;
  logic [7:0]        ram_rd;

  assign xfer = in_valid & in_ready & ~clear;
  // Length including a byte written this cycle, so a same-address fetch sees the new byte.
  assign len_eff = prog_len + {8'd0, xfer};

  prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (xfer),
    .waddr   (wr_ptr),
    .wdata   (in_data),
    .re      (fetch_req),
    .raddr   (fetch_addr[AW-1:0]),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= mp_pkg::IDLE;
      wr_ptr   <= '0;
      prog_len <= '0;
      loaded   <= 1'b0;
      overflow <= 1'b0;
      in_ready <= 1'b1;
    end else if (clear) begin
      state    <= mp_pkg::IDLE;
      wr_ptr   <= '0;
      prog_len <= '0;
      loaded   <= 1'b0;
      overflow <= 1'b0;
      in_ready <= 1'b1;
    end else if (xfer) begin
      wr_ptr   <= wr_ptr + 1'b1;
      prog_len <= prog_len + 9'd1;
      if (in_last) begin
        state    <= mp_pkg::READY;
        loaded   <= 1'b1;
        in_ready <= 1'b0;
      end else if (wr_ptr == AW'(DEPTH - 1)) begin
        state    <= mp_pkg::ERR;
        overflow <= 1'b1;
        in_ready <= 1'b0;
      end else begin
        state <= mp_pkg::LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      in_range_q  <= 1'b0;
    end else begin
      fetch_valid <= fetch_req;
      if (fetch_req) in_range_q <= ({1'b0, fetch_addr} < len_eff);
    end
  end

  // Out-of-range lines read as halt, masking stale RAM contents.
  assign fetch_data = in_range_q ? ram_rd : HALT_OP;
endmodule

// File: tb/tb_bytecode_loader.sv
// Directed bench: fetch expectations go through a scoreboard queue, status flags are checked inline.
module tb_bytecode_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       clear = 1'b0;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = 8'h00;
  logic [7:0] fetch_data;
  logic       fetch_valid;
  logic [8:0] prog_len;
  logic       loaded;
  logic       overflow;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q [$];

  bytecode_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .clear(clear), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .prog_len(prog_len),
    .loaded(loaded), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && fetch_valid) begin
      if (exp_q.size() == 0) chk("fetch_spurious", 32'(fetch_data), 32'hDEAD);
      else chk("fetch_data", 32'(fetch_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp);
    fetch_req = 1'b1; fetch_addr = a;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    // reset values
    #23;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_prog_len", 32'(prog_len), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_fetch_data", 32'(fetch_data), 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic load
    send(8'h02, 0); send(8'h01, 0); send(8'h05, 0); send(8'h03, 0);
    chk("load_loaded_early", 32'(loaded), 0);
    chk("load_in_ready", 32'(in_ready), 1);
    chk("load_len4", 32'(prog_len), 4);
    send(8'hFF, 1);
    chk("basic_prog_len", 32'(prog_len), 5);
    chk("basic_loaded", 32'(loaded), 1);
    chk("basic_in_ready", 32'(in_ready), 0);
    fetch(8'd2, 8'h05);
    fetch(8'd0, 8'h02);
    fetch(8'd3, 8'h03);
    @(posedge clk); #1;
    chk("idle_fetch_valid", 32'(fetch_valid), 0);
    chk("hold_fetch_data", 32'(fetch_data), 32'h03);
    fetch(8'd7, 8'hFF);
    send(8'h77, 0);
    chk("ready_backpressure", 32'(prog_len), 5);

    // clear from READY, then clear racing a transfer in IDLE
    do_clear();
    chk("clr_prog_len", 32'(prog_len), 0);
    chk("clr_loaded", 32'(loaded), 0);
    chk("clr_in_ready", 32'(in_ready), 1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("race_clr_prog_len", 32'(prog_len), 0);
    fetch(8'd0, 8'hFF);

    // LOAD-state fetches, stale masking and same-address race
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    chk("pre_race_len", 32'(prog_len), 4);
    fetch(8'd0, 8'h10);
    fetch(8'd1, 8'h20);
    fetch(8'd5, 8'hFF);
    in_valid = 1'b1; in_data = 8'h33; in_last = 1'b0;
    fetch_req = 1'b1; fetch_addr = 8'd4; exp_q.push_back(8'h33);
    @(posedge clk); #1;
    in_valid = 1'b0; fetch_req = 1'b0;
    chk("race_len", 32'(prog_len), 5);
    do_clear();
    send(8'h50, 0); send(8'h60, 0);
    fetch(8'd3, 8'hFF);

    // reset mid-load
    do_clear();
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_prog_len", 32'(prog_len), 0);
    chk("arst_loaded", 32'(loaded), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h11, 1);
    chk("post_rst_len", 32'(prog_len), 1);
    chk("post_rst_loaded", 32'(loaded), 1);
    fetch(8'd0, 8'h11);
    fetch(8'd1, 8'hFF);

    // overflow: 256 bytes without last
    do_clear();
    for (int i = 0; i < 255; i++) send(8'(i) ^ 8'h5A, 0);
    chk("ovf_pre_len", 32'(prog_len), 255);
    chk("ovf_pre_ready", 32'(in_ready), 1);
    chk("ovf_pre_flag", 32'(overflow), 0);
    send(8'hFF ^ 8'h5A, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_len", 32'(prog_len), 256);
    chk("ovf_in_ready", 32'(in_ready), 0);
    chk("ovf_loaded", 32'(loaded), 0);
    send(8'hEE, 0);
    chk("ovf_257_len", 32'(prog_len), 256);
    chk("ovf_sticky", 32'(overflow), 1);
    fetch(8'd255, 8'hA5);
    fetch(8'd0, 8'h5A);
    fetch(8'd128, 8'hDA);
    do_clear();
    chk("ovf_clr", 32'(overflow), 0);

    // full program with last on byte 256
    for (int i = 0; i < 255; i++) send(8'(i), 0);
    send(8'hC3, 1);
    chk("full_len", 32'(prog_len), 256);
    chk("full_loaded", 32'(loaded), 1);
    chk("full_overflow", 32'(overflow), 0);
    fetch(8'd255, 8'hC3);
    fetch(8'd100, 8'd100);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
